// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: parametrised inter-stage pipeline register with a valid/ready handshake.
// It holds up to two entries: a head (H) and a skid (S). Because of the skid entry, in_ready can
// be a registered signal and there is no combinational path from out_ready to in_ready. It also
// supports a synchronous flush, which inserts a bubble, and provides a dest-register hit output
// for the forwarding/hazard unit.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   flush               drop held entries and this cycle's input
//   in_valid/in_ready   upstream handshake (in_ready registered, low while reset held)
//   in_ctrl/rd/data     entry payload; data word k at [k*DATA_W +: DATA_W]
//   out_valid/out_ready downstream handshake on the head entry
//   out_ctrl/rd/data    head payload; out_ctrl forced to 0 when out_valid=0
//   hit_rd/hit          head will write hit_rd (combinational)
module pipe_stage_skid #(
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned DATA_N    = 3,
    parameter int unsigned CTRL_W    = 4,
    parameter int unsigned RD_W      = 5,
    parameter int unsigned REGWR_BIT = 1,
    parameter int unsigned ZERO_REG  = 31
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CTRL_W-1:0]        in_ctrl,
    input  logic [RD_W-1:0]          in_rd,
    input  logic [DATA_N*DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CTRL_W-1:0]        out_ctrl,
    output logic [RD_W-1:0]          out_rd,
    output logic [DATA_N*DATA_W-1:0] out_data,
    input  logic [RD_W-1:0]          hit_rd,
    output logic                     hit
);

    localparam int unsigned DW = DATA_N * DATA_W;

    typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

    state_e            state_q, state_d;
    logic              in_ready_q;
    logic [CTRL_W-1:0] h_ctrl_q, h_ctrl_d, s_ctrl_q, s_ctrl_d;
    logic [RD_W-1:0]   h_rd_q, h_rd_d, s_rd_q, s_rd_d;
    logic [DW-1:0]     h_data_q, h_data_d, s_data_q, s_data_d;
    logic              push, pop;

    // Registered ready, masked while reset is held so inputs are ignored during reset.
    assign in_ready  = in_ready_q & ~reset;
    assign out_valid = (state_q != StEmpty);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready;

    always_comb begin
        state_d  = state_q;
        h_ctrl_d = h_ctrl_q;
        h_rd_d   = h_rd_q;
        h_data_d = h_data_q;
        s_ctrl_d = s_ctrl_q;
        s_rd_d   = s_rd_q;
        s_data_d = s_data_q;
        unique case (state_q)
            StEmpty: begin
                if (push) begin
                    state_d  = StOne;
                    h_ctrl_d = in_ctrl;
                    h_rd_d   = in_rd;
                    h_data_d = in_data;
                end
            end
            StOne: begin
                if (push && pop) begin
                    h_ctrl_d = in_ctrl;
                    h_rd_d   = in_rd;
                    h_data_d = in_data;
                end else if (push) begin
                    state_d  = StTwo;
                    s_ctrl_d = in_ctrl;
                    s_rd_d   = in_rd;
                    s_data_d = in_data;
                end else if (pop) begin
                    state_d = StEmpty;
                end
            end
            StTwo: begin
                // in_ready is low here, so only a pop can happen; S moves up to keep order.
                if (pop) begin
                    state_d  = StOne;
                    h_ctrl_d = s_ctrl_q;
                    h_rd_d   = s_rd_q;
                    h_data_d = s_data_q;
                end
            end
            default: state_d = StEmpty;
        endcase
        if (flush) begin
            state_d = StEmpty;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StEmpty;
            in_ready_q <= 1'b1;
            h_ctrl_q   <= '0;
            h_rd_q     <= '0;
            h_data_q   <= '0;
            s_ctrl_q   <= '0;
            s_rd_q     <= '0;
            s_data_q   <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != StTwo);
            h_ctrl_q   <= h_ctrl_d;
            h_rd_q     <= h_rd_d;
            h_data_q   <= h_data_d;
            s_ctrl_q   <= s_ctrl_d;
            s_rd_q     <= s_rd_d;
            s_data_q   <= s_data_d;
        end
    end

    // Bubbles carry no control so they can never write memory, registers or flags.
    assign out_ctrl = out_valid ? h_ctrl_q : '0;
    assign out_rd   = h_rd_q;
    assign out_data = h_data_q;

    assign hit = out_valid & h_ctrl_q[REGWR_BIT] & (h_rd_q == hit_rd)
               & (h_rd_q != RD_W'(ZERO_REG));

endmodule
